// File: rtl/ecc_apb_pkg.sv
// Shared definitions for the ECC APB initiator: register map, op/status codes,
// sequencer states and the write-ordering helpers.
package ecc_apb_pkg;

  localparam logic [7:0] ADDR_CTRL           = 8'h00;
  localparam logic [7:0] ADDR_DATA_IN        = 8'h04;
  localparam logic [7:0] ADDR_CODEWORD_WIDTH = 8'h08;
  localparam logic [7:0] ADDR_NOISE          = 8'h0C;

  typedef enum logic [1:0] {
    OP_ENCODE  = 2'b00,
    OP_DECODE  = 2'b01,
    OP_FULL    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'b00,
    STATUS_TIMEOUT = 2'b01,
    STATUS_ILLEGAL = 2'b10,
    STATUS_RSVD    = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    X_DATA_IN = 2'd0,
    X_WIDTH   = 2'd1,
    X_NOISE   = 2'd2,
    X_CTRL    = 2'd3
  } xfer_e;

  function automatic logic [7:0] xfer_addr(input xfer_e x);
    case (x)
      X_DATA_IN: xfer_addr = ADDR_DATA_IN;
      X_WIDTH:   xfer_addr = ADDR_CODEWORD_WIDTH;
      X_NOISE:   xfer_addr = ADDR_NOISE;
      default:   xfer_addr = ADDR_CTRL;
    endcase
  endfunction

  // NOISE is only written for full-channel requests; CTRL always goes last.
  function automatic xfer_e next_xfer(input xfer_e x, input logic [1:0] op);
    case (x)
      X_DATA_IN: next_xfer = X_WIDTH;
      X_WIDTH:   next_xfer = (op == OP_FULL) ? X_NOISE : X_CTRL;
      default:   next_xfer = X_CTRL;
    endcase
  endfunction

endpackage

// File: rtl/ecc_apb_xfer.sv
// Two-cycle APB write engine: a start pulse loads a SETUP phase, the next cycle
// is ACCESS, then the bus returns to idle unless another start arrives.
module ecc_apb_xfer #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [AMBA_ADDR_WIDTH-1:0] i_addr,
  input  logic [AMBA_WORD-1:0]       i_data,
  output logic                       o_psel,
  output logic                       o_penable,
  output logic                       o_pwrite,
  output logic [AMBA_ADDR_WIDTH-1:0] o_paddr,
  output logic [AMBA_WORD-1:0]       o_pwdata,
  output logic                       o_last_cycle
);

  logic                       r_psel;
  logic                       r_penable;
  logic                       r_pwrite;
  logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
  logic [AMBA_WORD-1:0]       r_pwdata;

  // A start in the ACCESS cycle chains straight into the next SETUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else if (i_start) begin
      r_psel    <= 1'b1;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b1;
      r_paddr   <= i_addr;
      r_pwdata  <= i_data;
    end else if (r_psel && !r_penable) begin
      r_penable <= 1'b1;
    end else begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end
  end

  assign o_psel       = r_psel;
  assign o_penable    = r_penable;
  assign o_pwrite     = r_pwrite;
  assign o_paddr      = r_paddr;
  assign o_pwdata     = r_pwdata;
  assign o_last_cycle = r_psel & r_penable;

endmodule

// File: rtl/ecc_apb_master.sv
// Request/response front end for the ECC block: programs its registers over APB,
// waits for operation_done and returns the captured result or a timeout/illegal status.
module ecc_apb_master
  import ecc_apb_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [DATA_WIDTH-1:0]      req_data,
  input  logic [1:0]                 req_width,
  input  logic [DATA_WIDTH-1:0]      req_noise,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_err_num,
  output logic [1:0]                 rsp_status,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 err_num
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e                r_state;
  state_e                w_next_state;
  xfer_e                 r_xfer;
  xfer_e                 w_start_xfer;
  logic                  w_start;
  logic [1:0]            r_op;
  logic [1:0]            r_width;
  logic [DATA_WIDTH-1:0] r_noise;
  logic                  r_done_q;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_rsp_err;
  logic [1:0]            r_rsp_status;

  logic                       w_accept;
  logic                       w_rise;
  logic                       w_timeout;
  logic                       w_last_cycle;
  logic [AMBA_ADDR_WIDTH-1:0] w_xfer_addr;
  logic [AMBA_WORD-1:0]       w_xfer_data;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_rise    = operation_done && !r_done_q;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_start_xfer = X_DATA_IN;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (req_op == OP_ILLEGAL) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_SETUP;
            w_start      = 1'b1;
            w_start_xfer = X_DATA_IN;
          end
        end
      end
      S_SETUP: w_next_state = S_ACCESS;
      S_ACCESS: begin
        if (w_last_cycle && r_xfer == X_CTRL) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_SETUP;
          w_start      = 1'b1;
          w_start_xfer = next_xfer(r_xfer, r_op);
        end
      end
      S_WAIT: begin
        if (w_rise || w_timeout) w_next_state = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // DATA_IN is launched from IDLE before the request fields are latched, so it reads req_data directly.
  always_comb begin
    w_xfer_addr = AMBA_ADDR_WIDTH'(xfer_addr(w_start_xfer));
    w_xfer_data = '0;
    case (w_start_xfer)
      X_DATA_IN: w_xfer_data = AMBA_WORD'(req_data);
      X_WIDTH:   w_xfer_data = AMBA_WORD'(r_width);
      X_NOISE:   w_xfer_data = AMBA_WORD'(r_noise);
      default:   w_xfer_data = AMBA_WORD'(r_op);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op         <= '0;
      r_width      <= '0;
      r_noise      <= '0;
      r_xfer       <= X_DATA_IN;
      r_done_q     <= 1'b0;
      r_cnt        <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= '0;
      r_rsp_status <= STATUS_OK;
    end else begin
      r_done_q <= operation_done;
      if (w_accept) begin
        r_op    <= req_op;
        r_width <= req_width;
        r_noise <= req_noise;
      end
      if (w_start) r_xfer <= w_start_xfer;
      if (r_state == S_ACCESS && w_last_cycle && r_xfer == X_CTRL) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // A rising done wins over a timeout landing in the same cycle.
      if (w_accept && req_op == OP_ILLEGAL) begin
        r_rsp_data   <= '0;
        r_rsp_err    <= '0;
        r_rsp_status <= STATUS_ILLEGAL;
      end else if (r_state == S_WAIT) begin
        if (w_rise) begin
          r_rsp_data   <= data_out;
          r_rsp_err    <= err_num;
          r_rsp_status <= STATUS_OK;
        end else if (w_timeout) begin
          r_rsp_data   <= '0;
          r_rsp_err    <= '0;
          r_rsp_status <= STATUS_TIMEOUT;
        end
      end
    end
  end

  ecc_apb_xfer #(
    .AMBA_WORD      (AMBA_WORD),
    .AMBA_ADDR_WIDTH(AMBA_ADDR_WIDTH)
  ) u_xfer (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_addr      (w_xfer_addr),
    .i_data      (w_xfer_data),
    .o_psel      (PSEL),
    .o_penable   (PENABLE),
    .o_pwrite    (PWRITE),
    .o_paddr     (PADDR),
    .o_pwdata    (PWDATA),
    .o_last_cycle(w_last_cycle)
  );

  assign req_ready   = (r_state == S_IDLE);
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_data    = r_rsp_data;
  assign rsp_err_num = r_rsp_err;
  assign rsp_status  = r_rsp_status;

endmodule

// File: tb/tb_ecc_apb_master.sv
// Randomized bench for ecc_apb_master: a transaction-level model predicts the APB
// write sequence and the response timing/content, checked every cycle.
module tb_ecc_apb_master;

  localparam int T = 16;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic [1:0]  req_width;
  logic [31:0] req_noise;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err_num;
  logic [1:0]  rsp_status;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  err_num;

  ecc_apb_master #(
    .AMBA_WORD      (32),
    .AMBA_ADDR_WIDTH(20),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_data      (req_data),
    .req_width     (req_width),
    .req_noise     (req_noise),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err_num   (rsp_err_num),
    .rsp_status    (rsp_status),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PWRITE        (PWRITE),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .operation_done(operation_done),
    .data_out      (data_out),
    .err_num       (err_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic        en;
    logic        wr;
    logic [19:0] addr;
    logic [31:0] data;
  } apb_t;

  // Stimulus side-channel: written only by the driver, read by the model at accept.
  int          stimK = 0;
  logic [31:0] stimDout = '0;
  logic [1:0]  stimEn = '0;
  int          stimPin = 0;

  // Model state: written only by the model/compare process.
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          pending = 0;
  int          rspCycle = 0;
  logic [31:0] expData = '0;
  logic [1:0]  expErr = '0;
  logic [1:0]  expStatus = '0;
  int          pinActive = 0;
  int          pinBase = 0;
  apb_t        expQ[$];

  logic [19:0] pinAddr [0:5] = '{20'h4, 20'h4, 20'h8, 20'h8, 20'h0, 20'h0};
  logic [31:0] pinData [0:5] = '{32'hA5, 32'hA5, 32'h1, 32'h1, 32'h0, 32'h0};
  logic        pinEn   [0:5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic pushWrite(input logic [19:0] addr, input logic [31:0] data);
    expQ.push_back({1'b1, 1'b0, 1'b1, addr, data});
    expQ.push_back({1'b1, 1'b1, 1'b1, addr, data});
  endtask

  // Transaction-level prediction: list of register writes plus when/what the response is.
  task automatic acceptModel();
    int nW;
    pending   = 1;
    pinBase   = cyc;
    pinActive = stimPin;
    if (req_op == 2'b11) begin
      rspCycle  = cyc;
      expData   = '0;
      expErr    = '0;
      expStatus = 2'b10;
    end else begin
      pushWrite(20'h4, req_data);
      pushWrite(20'h8, {30'b0, req_width});
      if (req_op == 2'b10) pushWrite(20'hC, req_noise);
      pushWrite(20'h0, {30'b0, req_op});
      nW = (req_op == 2'b10) ? 4 : 3;
      if (stimK >= 1 && stimK <= T) begin
        rspCycle  = cyc + 2 * nW + stimK;
        expData   = stimDout;
        expErr    = stimEn;
        expStatus = 2'b00;
      end else begin
        rspCycle  = cyc + 2 * nW + T;
        expData   = '0;
        expErr    = '0;
        expStatus = 2'b01;
      end
    end
  endtask

  task automatic compareCycle();
    apb_t e;
    bit   expV;
    int   off;
    if (rst) begin
      checkOutput("reset_outputs",
                  {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_data, rsp_err_num, rsp_status, req_ready},
                  {3'b000, 20'h0, 32'h0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1});
    end else begin
      e = (expQ.size() > 0) ? expQ.pop_front() : '0;
      checkOutput("apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, e);
      checkOutput("req_ready", req_ready, !pending);
      expV = pending && (cyc >= rspCycle);
      checkOutput("rsp_valid", rsp_valid, expV);
      if (expV) checkOutput("rsp_fields", {rsp_data, rsp_err_num, rsp_status}, {expData, expErr, expStatus});
      off = cyc - pinBase;
      if (pinActive == 1 && off >= 0 && off <= 5)
        checkOutput("pin_encode_apb", {PSEL, PENABLE, PADDR, PWDATA}, {1'b1, pinEn[off], pinAddr[off], pinData[off]});
      if (pinActive == 1 && off == 6) checkOutput("pin_encode_idle", PSEL, 1'b0);
      if (pinActive == 2 && off == 4) checkOutput("pin_full_noise", {PADDR, PWDATA}, {20'hC, 32'h4});
      if (pinActive == 2 && expV)
        checkOutput("pin_full_rsp", {rsp_data, rsp_err_num, rsp_status}, {32'h12345678, 2'b01, 2'b00});
      if (pinActive == 4 && off == 21) checkOutput("pin_timeout_early", rsp_valid, 1'b0);
      if (pinActive == 4 && off == 22)
        checkOutput("pin_timeout_rsp", {rsp_valid, rsp_status, rsp_data}, {1'b1, 2'b01, 32'h0});
      if (pinActive == 5 && off == 0)
        checkOutput("pin_illegal", {PSEL, rsp_valid, rsp_status}, {1'b0, 1'b1, 2'b10});
      if (pinActive == 6 && off == 0)
        checkOutput("pin_after_reset", {PSEL, PENABLE, PADDR}, {1'b1, 1'b0, 20'h4});
    end
  endtask

  always begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst) begin
      expQ.delete();
      pending   = 0;
      pinActive = 0;
    end else if (pending && cyc > rspCycle && rsp_ready) begin
      pending = 0;
    end else if (!pending && req_valid) begin
      acceptModel();
    end
    @(negedge clk);
    compareCycle();
  end

  // k = WAIT cycle (1-based) in which done rises; 0 means no rise at all.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] data, input logic [1:0] width,
                               input logic [31:0] noise, input int k, input bit stale, input int bp,
                               input logic [31:0] dout, input logic [1:0] en, input int pin);
    int nW;
    stimK     = k;
    stimDout  = dout;
    stimEn    = en;
    stimPin   = pin;
    req_op    = op;
    req_data  = data;
    req_width = width;
    req_noise = noise;
    req_valid = 1'b1;
    if (stale) operation_done = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_data  = $urandom;
    req_width = 2'($urandom);
    req_noise = $urandom;
    data_out  = $urandom;
    err_num   = 2'($urandom);
    nW = (op == 2'b11) ? 0 : ((op == 2'b10) ? 4 : 3);
    if (op != 2'b11 && k > 0) begin
      repeat (2 * nW + k - 1) @(posedge clk);
      #1;
      operation_done = 1'b1;
      data_out       = dout;
      err_num        = en;
    end
    while (cyc < rspCycle) begin
      @(posedge clk);
      #1;
    end
    repeat (bp) begin
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready      = 1'b0;
    operation_done = 1'b0;
    data_out       = $urandom;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r;
    int k;
    bit stale;
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_op         = '0;
    req_data       = '0;
    req_width      = '0;
    req_noise      = '0;
    rsp_ready      = 1'b0;
    operation_done = 1'b0;
    data_out       = '0;
    err_num        = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] directed: encode");
    applyStimulus(2'b00, 32'hA5, 2'b01, 32'h0, 5, 0, 0, $urandom, 2'($urandom), 1);
    $display("[TB] directed: full channel");
    applyStimulus(2'b10, $urandom, 2'b10, 32'h4, 3, 0, 0, 32'h12345678, 2'b01, 2);
    $display("[TB] directed: backpressure then back-to-back");
    applyStimulus(2'b01, $urandom, 2'($urandom), $urandom, 7, 0, 5, $urandom, 2'($urandom), 0);
    applyStimulus(2'b00, $urandom, 2'($urandom), $urandom, 2, 0, 0, $urandom, 2'($urandom), 0);
    $display("[TB] directed: timeout with stale done");
    applyStimulus(2'b00, $urandom, 2'($urandom), $urandom, 0, 1, 0, $urandom, 2'($urandom), 4);
    $display("[TB] directed: rise on last wait cycle, and one cycle late");
    applyStimulus(2'b01, $urandom, 2'($urandom), $urandom, T, 0, 1, 32'hCAFEF00D, 2'b10, 0);
    applyStimulus(2'b10, $urandom, 2'($urandom), $urandom, T + 1, 0, 0, 32'h0BADBEEF, 2'b11, 0);
    $display("[TB] directed: illegal op");
    applyStimulus(2'b11, $urandom, 2'($urandom), $urandom, 1, 0, 0, $urandom, 2'($urandom), 5);

    $display("[TB] directed: reset during DATA_IN access");
    stimK     = 0;
    stimPin   = 0;
    req_op    = 2'b00;
    req_data  = $urandom;
    req_width = 2'b01;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(2'b00, $urandom, 2'($urandom), $urandom, 4, 0, 0, $urandom, 2'($urandom), 6);

    $display("[TB] random requests");
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      k = 0;
      else if (r == 1) k = T;
      else if (r == 2) k = T + 1;
      else             k = $urandom_range(1, T - 1);
      stale = (k == 0) && ($urandom_range(0, 1) == 1);
      applyStimulus(2'($urandom_range(0, 3)), $urandom, 2'($urandom), $urandom, k, stale,
                    $urandom_range(0, 3), $urandom, 2'($urandom), 0);
    end

    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
